// File: rtl/seg7_pkg.sv
// Package: seg7_pkg
// Purpose: shared constants for the 7-segment scan driver.
//   - Logical segment patterns for nibbles 0..F, bit order {g,f,e,d,c,b,a}
//     (bit 0 = segment a), plus SEG_BLANK.
//   - width_for(): counter width helper, never narrower than one bit.
//   - params_ok(): elaboration-time legality check of the driver parameters.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;

    // Width of a counter covering 0..n-1.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int digits, input int scan_div, input int guard);
        return (digits >= 1) && (digits <= 8) && (scan_div >= 2) &&
               (guard >= 0) && (guard < scan_div);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Interface: seg7_scan_driver_if
// Purpose: groups the display data inputs and board-pin outputs of the
//   scan driver.
//   en      : scan enable (low = dark, counters frozen)
//   data    : packed nibbles, digit i = data[4i+3:4i]
//   dp      : decimal point per digit
//   seg     : segment pins {g..a}
//   seg_dp  : decimal point pin
//   dig_sel : digit enable pins
// There is no handshake: data/dp are sampled only at frame boundaries, and
// the outputs are level signals that are meaningful every cycle.
// master = source of data (datapath side), slave = the driver.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp;
    logic [6:0]            seg;
    logic                  seg_dp;
    logic [DIGITS-1:0]     dig_sel;

    modport master (output en, data, dp, input seg, seg_dp, dig_sel);
    modport slave  (input en, data, dp, output seg, seg_dp, dig_sel);
endinterface

// File: rtl/seg7_hex_decode.sv
// Module: seg7_hex_decode
// Purpose: combinational nibble to logical 7-segment pattern {g..a}.
//   nib : 4-bit value
//   seg : pattern; values 10..15 decode to A b C d E F when HEX_MODE=1,
//         otherwise to blank.
module seg7_hex_decode
    import seg7_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = HEX_MODE ? SEG_A : SEG_BLANK;
            4'hB: seg = HEX_MODE ? SEG_B : SEG_BLANK;
            4'hC: seg = HEX_MODE ? SEG_C : SEG_BLANK;
            4'hD: seg = HEX_MODE ? SEG_D : SEG_BLANK;
            4'hE: seg = HEX_MODE ? SEG_E : SEG_BLANK;
            4'hF: seg = HEX_MODE ? SEG_F : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// Module: seg7_scan_driver
// Purpose: time-multiplexed driver for a DIGITS-wide 7-segment display.
//   Scans one digit per slot of SCAN_DIV cycles; the first GUARD cycles of
//   each slot are dark to avoid ghosting. data/dp are captured into shadow
//   registers only at the frame boundary so a frame never tears.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (priority over en)
//   bus  : seg7_scan_driver_if.slave (en, data, dp in; seg, seg_dp, dig_sel out)
// Note: bus must be instantiated with the same DIGITS as this module.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int GUARD       = 2,
    parameter bit HEX_MODE    = 1'b0,
    parameter bit LZ_BLANK    = 1'b1,
    parameter bit SEG_ACT_LOW = 1'b0,
    parameter bit DIG_ACT_LOW = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_driver_if.slave bus
);
    generate
        if (!params_ok(DIGITS, SCAN_DIV, GUARD)) begin : g_bad_params
            $error("seg7_scan_driver: illegal DIGITS/SCAN_DIV/GUARD");
        end
    endgenerate

    localparam int CW = width_for(SCAN_DIV);
    localparam int IW = width_for(DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [CW:0]   GUARD_C  = (CW + 1)'(GUARD);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [4*DIGITS-1:0]   sh_data;
    logic [DIGITS-1:0]     sh_dp;
    logic                  en_r;

    logic                  slot_end;
    logic                  frame_end;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // en is registered so the outputs depend on flops only. It samples en even
    // during reset, so with GUARD=0 digit 0 is lit straight out of reset.
    always_ff @(posedge clk) begin
        en_r <= bus.en;
        if (rst) begin
            cnt     <= '0;
            idx     <= '0;
            sh_data <= '0;
            sh_dp   <= '0;
        end else if (bus.en) begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (frame_end) begin
                sh_data <= bus.data;
                sh_dp   <= bus.dp;
            end
        end
    end

    // hi_zero[i]: digit i and every more significant digit are zero.
    logic [DIGITS-1:0] hi_zero;
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_hi_zero
            assign hi_zero[gi] = ~|sh_data[4*DIGITS-1:4*gi];
        end
    endgenerate

    logic [3:0] cur_nib;
    logic       cur_dp;
    logic       cur_lz;

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib = sh_data[4*i +: 4];
                cur_dp  = sh_dp[i];
                cur_lz  = LZ_BLANK && (i != 0) && hi_zero[i];
            end
        end
    end

    logic [6:0] dec_seg;

    seg7_hex_decode #(.HEX_MODE(HEX_MODE)) u_dec (
        .nib (cur_nib),
        .seg (dec_seg)
    );

    logic              dark;
    logic [6:0]        seg_l;
    logic              dp_l;
    logic [DIGITS-1:0] dig_l;

    assign dark  = !en_r || ({1'b0, cnt} < GUARD_C);
    assign seg_l = (dark || cur_lz) ? SEG_BLANK : dec_seg;
    assign dp_l  = dark ? 1'b0 : cur_dp;
    assign dig_l = dark ? '0 : (DIGITS'(1) << idx);

    assign bus.seg     = seg_l ^ {7{SEG_ACT_LOW}};
    assign bus.seg_dp  = dp_l ^ SEG_ACT_LOW;
    assign bus.dig_sel = dig_l ^ {DIGITS{DIG_ACT_LOW}};

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: two instances share one stimulus.
//   dut0: HEX_MODE=0, LZ_BLANK=1, active-high pins
//   dut1: HEX_MODE=1, LZ_BLANK=0, active-low segments and digit selects
// A slot-position reference model predicts every cycle of both instances;
// a vector table and hand sequences pin down specific display values.
module tb_seg7_scan_driver;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int GUARD    = 1;
    localparam int FRAME    = DIGITS * SCAN_DIV;
    localparam int W        = DIGITS + 8;

    // ---------------- clock / reset / DUTs ----------------
    logic clk;
    logic rst;
    logic en;
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0] dp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus0 ();
    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus1 ();

    assign bus0.en = en;
    assign bus0.data = data;
    assign bus0.dp = dp;
    assign bus1.en = en;
    assign bus1.data = data;
    assign bus1.dp = dp;

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD),
        .HEX_MODE(1'b0), .LZ_BLANK(1'b1), .SEG_ACT_LOW(1'b0), .DIG_ACT_LOW(1'b0)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD),
        .HEX_MODE(1'b1), .LZ_BLANK(1'b0), .SEG_ACT_LOW(1'b1), .DIG_ACT_LOW(1'b1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // ---------------- reference model ----------------
    logic [6:0] pat [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                             7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                             7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                             7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    int                  m_pos;   // position within the frame, 0..FRAME-1
    bit                  m_en_r;
    logic [4*DIGITS-1:0] m_sh;
    logic [DIGITS-1:0]   m_sdp;

    task automatic model_step();
        m_en_r = en;
        if (rst) begin
            m_pos = 0;
            m_sh  = '0;
            m_sdp = '0;
        end else if (en) begin
            if (m_pos == FRAME - 1) begin
                m_sh  = data;
                m_sdp = dp;
            end
            m_pos = (m_pos + 1) % FRAME;
        end
    endtask

    function automatic logic [W-1:0] model_pins(bit hex, bit lzb, bit sal, bit dal);
        int cnt = m_pos % SCAN_DIV;
        int idx = m_pos / SCAN_DIV;
        int nib;
        logic [6:0] s = '0;
        logic [DIGITS-1:0] d = '0;
        logic p = 1'b0;
        if (m_en_r && cnt >= GUARD) begin
            d   = DIGITS'(1 << idx);
            nib = int'((m_sh >> (4 * idx)) & 16'hF);
            s   = (nib >= 10 && !hex) ? 7'b0 : pat[nib];
            if (lzb && idx > 0 && (m_sh >> (4 * idx)) == 0) s = 7'b0;
            p   = m_sdp[idx];
        end
        if (sal) begin
            s = ~s;
            p = ~p;
        end
        if (dal) d = ~d;
        return {d, p, s};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s pos=%0d: got %h expected %h", name, m_pos, act, expv);
        end
    endtask

    function automatic logic [W-1:0] pins0();
        return {bus0.dig_sel, bus0.seg_dp, bus0.seg};
    endfunction

    function automatic logic [W-1:0] pins1();
        return {bus1.dig_sel, bus1.seg_dp, bus1.seg};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        exp_q.push_back(model_pins(1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(model_pins(1'b1, 1'b0, 1'b1, 1'b1));
        check("model_dut0", pins0(), exp_q.pop_front());
        check("model_dut1", pins1(), exp_q.pop_front());
    endtask

    task automatic goto_pos(input int target);
        int budget = 0;
        while (m_pos != target && budget < 4 * FRAME) begin
            tick();
            budget++;
        end
        if (m_pos != target) begin
            n_checks++;
            errors++;
            $display("FAIL goto_pos: got %0d expected %0d", m_pos, target);
        end
    endtask

    // Apply data/dp and run until they have been captured (position 0 of a new frame).
    task automatic load(input logic [15:0] d, input logic [3:0] p);
        data = d;
        dp   = p;
        goto_pos(FRAME - 1);
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        int          digit;
        logic [6:0]  seg0;   // dut0 pins
        logic        dp0;    // logical dp
        logic [6:0]  seg1;   // dut1 pins (active-low, hex, no LZ)
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{16'h1209, 4'b0100, 0, 7'b1101111, 1'b0, 7'b0010000};
        vecs[1]  = '{16'h1209, 4'b0100, 1, 7'b0111111, 1'b0, 7'b1000000};
        vecs[2]  = '{16'h1209, 4'b0100, 2, 7'b1011011, 1'b1, 7'b0100100};
        vecs[3]  = '{16'h1209, 4'b0100, 3, 7'b0000110, 1'b0, 7'b1111001};
        vecs[4]  = '{16'h0050, 4'b0000, 0, 7'b0111111, 1'b0, 7'b1000000};
        vecs[5]  = '{16'h0050, 4'b0000, 1, 7'b1101101, 1'b0, 7'b0010010};
        vecs[6]  = '{16'h0050, 4'b0000, 2, 7'b0000000, 1'b0, 7'b1000000};
        vecs[7]  = '{16'h0050, 4'b0000, 3, 7'b0000000, 1'b0, 7'b1000000};
        vecs[8]  = '{16'hABCF, 4'b0000, 0, 7'b0000000, 1'b0, 7'b0001110};
        vecs[9]  = '{16'hABCF, 4'b0000, 1, 7'b0000000, 1'b0, 7'b1000110};
        vecs[10] = '{16'hABCF, 4'b0000, 2, 7'b0000000, 1'b0, 7'b0000011};
        vecs[11] = '{16'hABCF, 4'b0000, 3, 7'b0000000, 1'b0, 7'b0001000};
        vecs[12] = '{16'h0000, 4'b1000, 0, 7'b0111111, 1'b0, 7'b1000000};
        vecs[13] = '{16'h0000, 4'b1000, 1, 7'b0000000, 1'b0, 7'b1000000};
        vecs[14] = '{16'h0000, 4'b1000, 2, 7'b0000000, 1'b0, 7'b1000000};
        vecs[15] = '{16'h0000, 4'b1000, 3, 7'b0000000, 1'b1, 7'b1000000};
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [DIGITS-1:0] onehot;
        rst    = 1'b1;
        en     = 1'b1;
        data   = '0;
        dp     = '0;
        m_pos  = 0;
        m_en_r = 1'b0;
        m_sh   = '0;
        m_sdp  = '0;

        // Reset: three cycles held, dark in the guard cycle, then digit 0 shows "0".
        repeat (3) tick();
        check("reset_dark", pins0(), '0);
        rst = 1'b0;
        tick();
        check("reset_digit0", pins0(), {4'b0001, 1'b0, 7'b0111111});
        goto_pos(6);
        check("reset_lz_digit1", pins0(), {4'b0010, 1'b0, 7'b0000000});

        // Table: each digit mid-slot, plus the dark first cycle of its slot.
        for (int v = 0; v < 16; v++) begin
            load(vecs[v].data, vecs[v].dp);
            onehot = DIGITS'(1 << vecs[v].digit);
            if (vecs[v].digit != 0) goto_pos(vecs[v].digit * SCAN_DIV);
            check("vec_guard0", pins0(), '0);
            check("vec_guard1", pins1(), {4'b1111, 1'b1, 7'b1111111});
            goto_pos(vecs[v].digit * SCAN_DIV + 2);
            check("vec_dut0", pins0(), {onehot, vecs[v].dp0, vecs[v].seg0});
            check("vec_dut1", pins1(), {~onehot, ~vecs[v].dp0, vecs[v].seg1});
        end

        // Mid-frame data change is invisible until the next frame.
        load(16'h1209, 4'b0100);
        goto_pos(5);
        data = 16'h0050;
        dp   = 4'b0000;
        goto_pos(10);
        check("midframe_hold2", pins0(), {4'b0100, 1'b1, 7'b1011011});
        goto_pos(14);
        check("midframe_hold3", pins0(), {4'b1000, 1'b0, 7'b0000110});
        goto_pos(FRAME - 1);
        tick();
        goto_pos(2);
        check("midframe_new0", pins0(), {4'b0001, 1'b0, 7'b0111111});
        goto_pos(6);
        check("midframe_new1", pins0(), {4'b0010, 1'b0, 7'b1101101});

        // en low at idx=2, cnt=2 for 10 cycles: dark and frozen, resumes at cnt=3.
        load(16'h1209, 4'b0100);
        goto_pos(10);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("en_low_dark", pins0(), '0);
        end
        en = 1'b1;
        tick();
        check("en_resume", pins0(), {4'b0100, 1'b1, 7'b1011011});
        tick();
        check("en_resume_guard", pins0(), '0);

        // Random stimulus against the model (checked inside tick).
        for (int k = 0; k < 800; k++) begin
            logic [15:0] r;
            int keep;
            r    = 16'($urandom);
            keep = $urandom_range(0, 4);
            data = (keep == 4) ? r : (r & ((16'h1 << (4 * keep)) - 16'h1));
            dp   = 4'($urandom_range(0, 15));
            en   = ($urandom_range(0, 9) != 0);
            rst  = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, n_checks);
        $finish;
    end

endmodule
